// File: rtl/clock_select_pkg.sv
// Shared types and address-map constants for the HS/LS clock speed-select controller.
package clock_select_pkg;

  // Which clock the CPU is on, or which one it is being moved to.
  typedef enum logic [1:0] {
    S_LS    = 2'd0,
    S_TO_HS = 2'd1,
    S_HS    = 2'd2,
    S_TO_LS = 2'd3
  } state_t;

  // Bank that always maps to host memory (default value for HOST_BANK).
  localparam logic [7:0] BANK_HOST_DEF = 8'hFF;
  // Bank 0: its upper 32K is host ROM/IO, so it must run on LS.
  localparam logic [7:0] BANK_LOCAL0 = 8'h00;
  // Lower bound of the bank-0 host window; the window runs to the top of the bank.
  localparam logic [15:0] IO_WIN_LO = 16'h8000;

  // True when a bank-0 offset falls inside the host window.
  function automatic logic in_io_win(input logic [15:0] offs);
    return offs >= IO_WIN_LO;
  endfunction

endpackage

// File: rtl/clock_select_ctrl_m_sync2.sv
// Two-flop synchroniser for one switch status bit.
module sync2_m (
  input  logic clk,
  input  logic resetb,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture of the asynchronous input; both stages clear on reset.
  always_ff @(posedge clk) begin
    if (!resetb) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/clock_select_ctrl_m.sv
// Speed-select controller: decodes each CPU cycle, requests HS or LS from the clock switch,
// and stalls the CPU until the switch reports the requested clock.
//
// state   | meaning
// S_LS    | running on LS; dwell counter gates the next HS request
// S_TO_HS | HS requested, CPU stalled until switch reports HS
// S_HS    | running on HS (local RAM with turbo on)
// S_TO_LS | LS requested, CPU stalled until switch reports LS
module clock_select_ctrl_m
  import clock_select_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 24,
  parameter logic [7:0]        HOST_BANK = BANK_HOST_DEF,
  parameter logic [ADDR_W-1:0] CTRL_ADDR = 'h00FE30,
  parameter int unsigned       LS_DWELL  = 4,
  parameter int unsigned       TIMEOUT   = 255
) (
  input  logic              hs_ck_ip,
  input  logic              resetb,
  input  logic              cyc_valid_ip,
  input  logic [ADDR_W-1:0] addr_ip,
  input  logic              rnw_ip,
  input  logic [7:0]        data_ip,
  input  logic              selected_hs_ip,
  input  logic              selected_ls_ip,
  output logic              select_hs_op,
  output logic              rdy_op,
  output logic              turbo_op,
  output logic              fault_op
);

  localparam int unsigned DW_W = $clog2(LS_DWELL + 1);
  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

  state_t          state, state_nxt;
  logic [DW_W-1:0] dwell;
  logic [TO_W-1:0] tmo;
  logic            shs, sls;
  logic [7:0]      bank;
  logic            ctrl_hit, want_ls, dwell_done, tmo_hit, tmo_sat, tmo_fire;
  logic            in_trans, ls_done;
  logic            pend_vld, pend_dat;
  logic            unused_data;

  // Upper control-register bits carry no function.
  assign unused_data = ^data_ip[7:1];

  sync2_m u_sync_hs (.clk(hs_ck_ip), .resetb(resetb), .d(selected_hs_ip), .q(shs));
  sync2_m u_sync_ls (.clk(hs_ck_ip), .resetb(resetb), .d(selected_ls_ip), .q(sls));

  assign bank       = addr_ip[ADDR_W-1 -: 8];
  assign ctrl_hit   = cyc_valid_ip && !rnw_ip && (addr_ip == CTRL_ADDR);
  assign dwell_done = (dwell == DW_W'(LS_DWELL));
  // Fire one cycle early so the fault lands on the edge where the count reaches TIMEOUT.
  assign tmo_hit    = (tmo == TO_W'(TIMEOUT - 1));
  assign tmo_sat    = (tmo == TO_W'(TIMEOUT));
  assign in_trans   = (state == S_TO_HS) || (state == S_TO_LS);
  assign ls_done    = (state == S_TO_LS) && (state_nxt == S_LS);

  // Address decode: anything host-side, or any access once faulted, must run on LS.
  assign want_ls = !turbo_op || fault_op || (bank == HOST_BANK) ||
                   ((bank == BANK_LOCAL0) && in_io_win(addr_ip[15:0])) || ctrl_hit;

  // Next state, stall and timeout decisions; stall reacts in the same cycle as the strobe.
  always_comb begin
    state_nxt = state;
    rdy_op    = 1'b1;
    tmo_fire  = 1'b0;
    case (state)
      S_LS: begin
        if (cyc_valid_ip && !want_ls && dwell_done) begin
          state_nxt = S_TO_HS;
          rdy_op    = 1'b0;
        end
      end
      S_TO_HS: begin
        rdy_op = 1'b0;
        if (shs && !sls) begin
          state_nxt = S_HS;
        end else if (tmo_hit) begin
          state_nxt = S_LS;
          tmo_fire  = 1'b1;
        end
      end
      S_HS: begin
        if (cyc_valid_ip && want_ls) begin
          state_nxt = S_TO_LS;
          rdy_op    = 1'b0;
        end
      end
      S_TO_LS: begin
        rdy_op = 1'b0;
        if (sls && !shs) begin
          state_nxt = S_LS;
        end else if (tmo_hit) begin
          state_nxt = S_LS;
          tmo_fire  = 1'b1;
        end
      end
      default: state_nxt = S_LS;
    endcase
  end

  assign select_hs_op = (state == S_TO_HS) || (state == S_HS);

  // State, counters, turbo bit and sticky fault; a turbo write seen on HS waits for LS.
  always_ff @(posedge hs_ck_ip) begin
    if (!resetb) begin
      state    <= S_LS;
      dwell    <= '0;
      tmo      <= '0;
      turbo_op <= 1'b0;
      fault_op <= 1'b0;
      pend_vld <= 1'b0;
      pend_dat <= 1'b0;
    end else begin
      state <= state_nxt;

      if (state == S_LS) begin
        if (!dwell_done) dwell <= dwell + DW_W'(1);
      end else begin
        dwell <= '0;
      end

      if (in_trans) begin
        if (!tmo_sat) tmo <= tmo + TO_W'(1);
      end else begin
        tmo <= '0;
      end

      if (tmo_fire) fault_op <= 1'b1;

      if ((state == S_LS) && ctrl_hit) begin
        turbo_op <= data_ip[0];
      end else if (ls_done && pend_vld) begin
        turbo_op <= pend_dat;
      end

      if ((state == S_HS) && ctrl_hit) begin
        pend_vld <= 1'b1;
        pend_dat <= data_ip[0];
      end else if (ls_done) begin
        pend_vld <= 1'b0;
      end
    end
  end

endmodule
